vedic_mac_accumulator: RTL and testbench
========================================

Name: vedic_mac_accumulator

Overview:
- Sequential consumer stage directly downstream of the 32x32 Vedic multiplier.
- Accepts a stream of 64-bit unsigned products over a valid/ready handshake and sums a programmed number of them (dot-product length) into a wide accumulator.
- Returns the total with a sticky overflow flag over a second valid/ready handshake.
- Internally: one product register stage, then one accumulate stage.

Parameters:
- PROD_W, 64, product width; matches multiplier output.
- ACC_W, 72, accumulator width; must be >= PROD_W.
- LEN_W, 16, width of the length field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin new accumulation; sampled only in IDLE.
- len  input  LEN_W  number of products to sum; sampled with start.
- in_valid  input  1  in_prod valid.
- in_ready  output  1  block accepts in_prod.
- in_prod  input  PROD_W  unsigned product from multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_acc  output  ACC_W  accumulated sum, modulo 2^ACC_W.
- out_ovf  output  1  sticky: some add carried out of ACC_W.
- busy  output  1  state != IDLE.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous, active-high.
- Reset (any state, including mid-operation):
  - state=IDLE.
  - in_ready=0, out_valid=0, busy=0.
  - acc=0, out_ovf=0, remaining count=0, stage valid p_vld=0.
  - Products in flight are discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0; products presented here are not consumed.
  - start=1 with len!=0: acc<=0, ovf<=0, remain<=len, go to ACCUM.
  - start=1 with len=0: acc<=0, ovf<=0, go to DONE. out_valid=1 from the next cycle.
- ACCUM:
  - in_ready = (remain != 0). Driven from registers only; no combinational path from in_valid.
  - Handshake (in_valid & in_ready) at edge k:
    - p_reg<=in_prod, p_vld<=1, remain<=remain-1.
    - Cycles without a handshake set p_vld<=0.
  - Accumulate: when p_vld=1 at edge k+1, {carry,acc} <= acc + zero-extended p_reg; ovf <= ovf | carry. acc wraps.
  - Leave for DONE at the edge where remain==0 and p_vld==1 (the final add).
  - Final-beat handshake at edge k gives out_valid=1 after edge k+1 (one-cycle latency).
  - in_valid gaps are tolerated; remain does not decrement on them.
  - start is ignored.
- DONE:
  - out_valid=1; out_acc and out_ovf held stable; in_ready=0.
  - out_valid & out_ready at an edge: go to IDLE; out_valid=0 next cycle.
  - start asserted while in DONE, including the handshake cycle, is ignored. A start must be presented in IDLE.
  - out_acc and out_ovf keep their last values in IDLE until the next start clears them.
- Width rules: all arithmetic unsigned; in_prod zero-extended to ACC_W.
- Throughput: one product per cycle sustained.
- Back-to-back jobs: minimum one IDLE cycle between result handshake and next start.

Test Plan:
- Basic sum: start, len=3; products 5, 7, 11 on consecutive cycles → in_ready drops after the 3rd beat; out_valid one cycle after the last handshake; out_acc=23, out_ovf=0.
- Zero length: start, len=0 → out_valid=1 next cycle, out_acc=0. in_valid held high with in_prod=99 throughout → never accepted.
- Overflow: ACC_W=64; len=2; products 0xFFFF_FFFE_0000_0001 twice → out_acc=0xFFFF_FFFC_0000_0002, out_ovf=1.
- Backpressure and gaps, with len=4:
  - Inputs 1, 2, 3, 4 with idle cycles between beats, plus an extra in_valid beat (value 100) after the 4th → out_acc=10; extra beat not consumed.
  - Hold out_ready=0 for 5 cycles → out_acc stable, busy=1, start pulses ignored.
- Reset mid-operation: len=4; after 2 beats (values 8, 8) assert rst for one cycle → next cycle all outputs zero, state IDLE. Then start, len=1, product 9 → out_acc=9, out_ovf=0.
- Full-rate multiplier feed: drive in_prod from a 32x32 multiplier with pairs (0xFFFFFFFF, 0xFFFFFFFF) ×3, len=3 → out_acc=0x2_FFFF_FFFA_0000_0003, out_ovf=0.

Source files
------------

// File: rtl/vedic_mac_accumulator.sv
// rtl/vedic_mac_accumulator.sv - product stream to wide accumulator with sticky overflow
module vedic_mac_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   remain;
    logic [PROD_W-1:0]  p_reg;
    logic               p_vld;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [ACC_W:0]     sum;
    logic               in_fire;
    logic               final_add;

    // in_ready comes from registers only so upstream sees no in_valid loop
    assign in_ready  = (state == ACCUM) && (remain != '0);
    assign in_fire   = in_valid && in_ready;
    assign final_add = (state == ACCUM) && p_vld && (remain == '0);
    assign sum       = {1'b0, acc} + (ACC_W + 1)'(p_reg);

    assign out_valid = (state == DONE);
    assign out_acc   = acc;
    assign out_ovf   = ovf;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (final_add) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            remain <= '0;
            p_reg  <= '0;
            p_vld  <= 1'b0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            p_vld <= in_fire;
            if (in_fire) begin
                p_reg  <= in_prod;
                remain <= remain - LEN_W'(1);
            end
            // p_vld can only be set while accumulating, so the two branches never collide
            if ((state == IDLE) && start) begin
                acc    <= '0;
                ovf    <= 1'b0;
                remain <= len;
            end else if (p_vld) begin
                acc <= sum[ACC_W-1:0];
                ovf <= ovf | sum[ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// tb/tb_vedic_mac_accumulator.sv - directed self-checking bench for vedic_mac_accumulator
module tb_vedic_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        in_valid;
    logic [63:0] in_prod;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [71:0] out_acc;
    logic        out_ovf;
    logic        busy;

    logic        in_ready_64;
    logic        out_valid_64;
    logic [63:0] out_acc_64;
    logic        out_ovf_64;
    logic        busy_64;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vedic_mac_accumulator #(.PROD_W(64), .ACC_W(72), .LEN_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
    );

    vedic_mac_accumulator #(.PROD_W(64), .ACC_W(64), .LEN_W(16)) u_dut64 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_64), .in_prod(in_prod),
        .out_valid(out_valid_64), .out_ready(out_ready),
        .out_acc(out_acc_64), .out_ovf(out_ovf_64), .busy(busy_64)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [63:0] v);
        in_prod  = v;
        in_valid = 1'b1;
        check(tag, in_ready, 1);
        tick();
    endtask

    function automatic logic [63:0] mul32(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {32'd0, a};
        eb = {32'd0, b};
        return ea * eb;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_acc", out_acc, 0);
        check("rst_ovf", out_ovf, 0);

        // basic sum 5+7+11
        start = 1'b1; len = 16'd3;
        tick();
        start = 1'b0;
        check("basic_busy", busy, 1);
        beat("basic_rdy0", 64'd5);
        beat("basic_rdy1", 64'd7);
        beat("basic_rdy2", 64'd11);
        in_valid = 1'b0;
        check("basic_rdy_drop", in_ready, 0);
        check("basic_not_yet", out_valid, 0);
        tick();
        check("basic_valid", out_valid, 1);
        check("basic_acc", out_acc, 72'd23);
        check("basic_ovf", out_ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("basic_idle_valid", out_valid, 0);
        check("basic_idle_busy", busy, 0);
        check("basic_idle_hold", out_acc, 72'd23);

        // zero length, in_valid held high throughout
        in_valid = 1'b1; in_prod = 64'd99;
        check("zero_idle_rdy", in_ready, 0);
        start = 1'b1; len = 16'd0;
        tick();
        start = 1'b0;
        check("zero_valid", out_valid, 1);
        check("zero_acc", out_acc, 0);
        check("zero_rdy", in_ready, 0);
        tick();
        check("zero_acc_hold", out_acc, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("zero_back_idle", busy, 0);
        check("zero_acc_after", out_acc, 0);

        // overflow on the 64-bit instance, no overflow on the 72-bit one
        start = 1'b1; len = 16'd2;
        tick();
        start = 1'b0;
        beat("ovf_rdy0", 64'hFFFF_FFFE_0000_0001);
        beat("ovf_rdy1", 64'hFFFF_FFFE_0000_0001);
        in_valid = 1'b0;
        tick();
        check("ovf64_valid", out_valid_64, 1);
        check("ovf64_acc", out_acc_64, 64'hFFFF_FFFC_0000_0002);
        check("ovf64_ovf", out_ovf_64, 1);
        check("ovf72_acc", out_acc, 72'h1_FFFF_FFFC_0000_0002);
        check("ovf72_ovf", out_ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // gaps plus an extra beat after the last one
        start = 1'b1; len = 16'd4;
        tick();
        start = 1'b0;
        check("gap_ovf_cleared", out_ovf_64, 0);
        beat("gap_rdy0", 64'd1);
        in_valid = 1'b0; tick();
        beat("gap_rdy1", 64'd2);
        in_valid = 1'b0; tick();
        beat("gap_rdy2", 64'd3);
        in_valid = 1'b0; tick(); tick();
        beat("gap_rdy3", 64'd4);
        in_prod = 64'd100;
        check("gap_extra_rdy", in_ready, 0);
        tick();
        check("gap_valid", out_valid, 1);
        check("gap_acc", out_acc, 72'd10);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 16'd7;
            tick();
            check("bp_acc", out_acc, 72'd10);
            check("bp_busy", busy, 1);
            check("bp_valid", out_valid, 1);
        end
        start = 1'b0;
        in_valid = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("bp_hs_idle", busy, 0);
        check("bp_hs_valid", out_valid, 0);
        tick();
        check("bp_start_ignored", busy, 0);
        check("bp_acc_idle", out_acc, 72'd10);

        // reset mid-operation
        start = 1'b1; len = 16'd4;
        tick();
        start = 1'b0;
        beat("mid_rdy0", 64'd8);
        beat("mid_rdy1", 64'd8);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rdy", in_ready, 0);
        check("mid_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_acc", out_acc, 0);
        check("mid_ovf", out_ovf, 0);
        tick();
        check("mid_acc_still", out_acc, 0);
        start = 1'b1; len = 16'd1;
        tick();
        start = 1'b0;
        beat("mid_rdy_new", 64'd9);
        in_valid = 1'b0;
        tick();
        check("mid_new_valid", out_valid, 1);
        check("mid_new_acc", out_acc, 72'd9);
        check("mid_new_ovf", out_ovf, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // full-rate feed from a 32x32 multiplier
        start = 1'b1; len = 16'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat("mul_rdy", mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF));
        end
        in_valid = 1'b0;
        check("mul_rdy_drop", in_ready, 0);
        tick();
        check("mul_valid", out_valid, 1);
        check("mul_acc", out_acc, 72'h2_FFFF_FFFA_0000_0003);
        check("mul_ovf", out_ovf, 0);
        check("mul64_acc", out_acc_64, 64'hFFFF_FFFA_0000_0003);
        check("mul64_ovf", out_ovf_64, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mul_end_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
